qeciphy_pbus_responder: RTL and testbench

- Device-side P-channel responder for the QECi PHY; consumes preq/pstate from the power controller and returns paccept/pactive.
- Sequences the PHY datapath through quiesce before power-down and through a settle delay before power-up.
- Always accepts (no deny path); sits between the P-channel pins and the PHY power/clock-enable logic.

---
 rtl/qeciphy_pbus_pkg.sv | 17 +
 rtl/qeciphy_pbus_timer.sv | 19 +
 rtl/qeciphy_pbus_responder.sv | 95 +++++++++
 tb/tb_qeciphy_pbus_responder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/qeciphy_pbus_pkg.sv
// qeciphy_pbus_pkg: shared FSM state type, power-state constants and counter sizing for the P-channel responder
package qeciphy_pbus_pkg;
  typedef enum logic [2:0] {
    ON_STABLE,
    QUIESCE,
    OFF_ACCEPT,
    OFF_STABLE,
    PWRUP,
    ON_ACCEPT,
    NOP_ACCEPT
  } pbus_state_e;
  localparam logic PSTATE_ON = 1'b1;
  localparam logic PSTATE_OFF = 1'b0;
  function automatic int cnt_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/qeciphy_pbus_timer.sv
// qeciphy_pbus_timer: loadable saturating down-counter with a done flag at zero
module qeciphy_pbus_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign done = cnt == '0;
endmodule

// File: rtl/qeciphy_pbus_responder.sv
// qeciphy_pbus_responder: device-side P-channel responder sequencing quiesce before power-down and settle before power-up
module qeciphy_pbus_responder
  import qeciphy_pbus_pkg::*;
#(
  parameter int   PWRUP_CYCLES    = 16,
  parameter int   QUIESCE_TIMEOUT = 1024,
  parameter logic RESET_PSTATE    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic preq,
  input  logic pstate,
  output logic paccept,
  output logic pactive,
  input  logic wake_req,
  input  logic busy,
  output logic quiesce_req,
  input  logic quiesce_ack,
  output logic power_en,
  output logic cur_pstate,
  output logic quiesce_timeout_evt,
  output logic proto_err
);
  localparam int W = cnt_w(PWRUP_CYCLES, QUIESCE_TIMEOUT);
  localparam logic [W-1:0] PWR_LD = W'(PWRUP_CYCLES - 1);
  localparam logic [W-1:0] QSC_LD = W'(QUIESCE_TIMEOUT == 0 ? 0 : QUIESCE_TIMEOUT - 1);
  pbus_state_e state;
  logic ack_q, stable, t_load, t_en, t_done, early_err, ack_err;
  logic [W-1:0] t_val;
  always_comb begin
    stable = state == ON_STABLE || state == OFF_STABLE;
    t_load = stable && preq && pstate != cur_pstate;
    t_val = pstate ? PWR_LD : QSC_LD;
    t_en = state == QUIESCE || state == PWRUP;
    early_err = t_en && (!preq || pstate != (state == PWRUP ? PSTATE_ON : PSTATE_OFF));
    ack_err = quiesce_ack && !ack_q && state != QUIESCE;
  end
  qeciphy_pbus_timer #(.W(W)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(t_load),
    .en(t_en),
    .load_val(t_val),
    .done(t_done)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RESET_PSTATE ? ON_STABLE : OFF_STABLE;
      power_en <= RESET_PSTATE;
      cur_pstate <= RESET_PSTATE;
      paccept <= 1'b0;
      quiesce_req <= 1'b0;
      pactive <= 1'b0;
      quiesce_timeout_evt <= 1'b0;
      proto_err <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      pactive <= wake_req | busy;
      ack_q <= quiesce_ack;
      quiesce_timeout_evt <= 1'b0;
      if (early_err || ack_err) proto_err <= 1'b1;
      case (state)
        ON_STABLE, OFF_STABLE: if (preq) begin
          if (pstate == cur_pstate) begin
            state <= NOP_ACCEPT;
            paccept <= 1'b1;
          end else if (pstate == PSTATE_ON) begin
            state <= PWRUP;
            power_en <= 1'b1;
          end else begin
            state <= QUIESCE;
            quiesce_req <= 1'b1;
          end
        end
        QUIESCE: if (quiesce_ack || (QUIESCE_TIMEOUT != 0 && t_done)) begin
          state <= OFF_ACCEPT;
          quiesce_req <= 1'b0;
          power_en <= 1'b0;
          cur_pstate <= PSTATE_OFF;
          paccept <= 1'b1;
          quiesce_timeout_evt <= !quiesce_ack;
        end
        PWRUP: if (t_done) begin
          state <= ON_ACCEPT;
          cur_pstate <= PSTATE_ON;
          paccept <= 1'b1;
        end
        default: if (!preq) begin
          state <= cur_pstate ? ON_STABLE : OFF_STABLE;
          paccept <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_qeciphy_pbus_responder.sv
// tb_qeciphy_pbus_responder: directed vector table plus handshake sequences for the P-channel responder
module tb_qeciphy_pbus_responder;
  localparam int P = 16;
  localparam int QT = 8;
  logic clk = 1'b0, rst = 1'b1, preq = 1'b0, pstate = 1'b0;
  logic wake_req = 1'b0, busy = 1'b0, quiesce_ack = 1'b0;
  logic paccept, pactive, quiesce_req, power_en, cur_pstate, quiesce_timeout_evt, proto_err;
  logic [6:0] outs;
  int n_chk = 0, n_err = 0;
  int lat, ev;
  typedef struct packed {
    logic [4:0] in;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs [16];
  always #5 clk = ~clk;
  assign outs = {paccept, power_en, cur_pstate, quiesce_req, quiesce_timeout_evt, proto_err, pactive};
  qeciphy_pbus_responder #(
    .PWRUP_CYCLES(P),
    .QUIESCE_TIMEOUT(QT),
    .RESET_PSTATE(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .preq(preq),
    .pstate(pstate),
    .paccept(paccept),
    .pactive(pactive),
    .wake_req(wake_req),
    .busy(busy),
    .quiesce_req(quiesce_req),
    .quiesce_ack(quiesce_ack),
    .power_en(power_en),
    .cur_pstate(cur_pstate),
    .quiesce_timeout_evt(quiesce_timeout_evt),
    .proto_err(proto_err)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic handshake(input logic tgt, output int l, output int e);
    preq = 1'b1;
    pstate = tgt;
    l = 0;
    e = 0;
    do begin
      tick();
      l++;
      e += int'(quiesce_timeout_evt);
    end while (!paccept && l < 100);
    chk("hs_accept", 32'(paccept), 1);
    tick();
    e += int'(quiesce_timeout_evt);
    chk("hs_hold", 32'(paccept), 1);
    preq = 1'b0;
    tick();
    e += int'(quiesce_timeout_evt);
    chk("hs_release", 32'({paccept, cur_pstate}), {31'd0, tgt});
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    vecs[0]  = {5'b11000, 7'b1110000};
    vecs[1]  = {5'b11000, 7'b1110000};
    vecs[2]  = {5'b00000, 7'b0110000};
    vecs[3]  = {5'b00010, 7'b0110001};
    vecs[4]  = {5'b00001, 7'b0110001};
    vecs[5]  = {5'b00000, 7'b0110000};
    vecs[6]  = {5'b10000, 7'b0111000};
    vecs[7]  = {5'b10000, 7'b0111000};
    vecs[8]  = {5'b10000, 7'b0111000};
    vecs[9]  = {5'b10000, 7'b0111000};
    vecs[10] = {5'b10000, 7'b0111000};
    vecs[11] = {5'b10100, 7'b1000000};
    vecs[12] = {5'b10000, 7'b1000000};
    vecs[13] = {5'b00000, 7'b0000000};
    vecs[14] = {5'b10000, 7'b1000000};
    vecs[15] = {5'b00000, 7'b0000000};
    tick();
    tick();
    chk("reset", 32'(outs), 0);
    rst = 1'b0;
    repeat (7) tick();
    preq = 1'b1;
    pstate = 1'b1;
    tick();
    chk("pwrup_en", 32'({paccept, power_en}), 'b01);
    repeat (P - 1) tick();
    chk("pwrup_wait", 32'({paccept, power_en}), 'b01);
    tick();
    chk("pwrup_accept", 32'({paccept, cur_pstate}), 'b11);
    repeat (3) tick();
    preq = 1'b0;
    tick();
    chk("pwrup_release", 32'({paccept, cur_pstate, power_en}), 'b011);
    for (int i = 0; i < 16; i++) begin
      {preq, pstate, quiesce_ack, wake_req, busy} = vecs[i].in;
      tick();
      chk($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end
    {preq, pstate, quiesce_ack, wake_req, busy} = 5'b0;
    handshake(1'b1, lat, ev);
    chk("pwrup_lat", lat, P + 1);
    handshake(1'b0, lat, ev);
    chk("timeout_lat", lat, QT + 1);
    chk("timeout_evt_count", ev, 1);
    chk("timeout_off", 32'({cur_pstate, power_en, proto_err, quiesce_req}), 0);
    handshake(1'b1, lat, ev);
    chk("pwrup_lat2", lat, P + 1);
    preq = 1'b1;
    pstate = 1'b0;
    tick();
    pstate = 1'b1;
    tick();
    chk("toggle_err", 32'({proto_err, quiesce_req}), 'b11);
    pstate = 1'b0;
    lat = 0;
    while (!paccept && lat < 50) begin
      tick();
      lat++;
    end
    chk("toggle_target", 32'({paccept, cur_pstate, power_en}), 'b100);
    preq = 1'b0;
    tick();
    tick();
    chk("err_sticky", 32'({proto_err, paccept}), 'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared_by_rst", 32'(outs), 0);
    preq = 1'b1;
    pstate = 1'b1;
    tick();
    preq = 1'b0;
    tick();
    chk("early_err", 32'(proto_err), 1);
    lat = 0;
    while (!paccept && lat < 50) begin
      tick();
      lat++;
    end
    chk("early_accept", 32'({paccept, cur_pstate}), 'b11);
    tick();
    chk("early_pulse", 32'({paccept, cur_pstate, power_en, proto_err}), 'b0111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    quiesce_ack = 1'b1;
    tick();
    quiesce_ack = 1'b0;
    chk("ack_outside", 32'(outs), 'b0000010);
    tick();
    chk("ack_outside_sticky", 32'(proto_err), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    preq = 1'b1;
    pstate = 1'b1;
    repeat (5) tick();
    chk("in_pwrup", 32'({power_en, paccept}), 'b10);
    rst = 1'b1;
    preq = 1'b0;
    tick();
    chk("rst_pwrup", 32'(outs), 0);
    rst = 1'b0;
    handshake(1'b1, lat, ev);
    chk("pwrup_after_rst", lat, P + 1);
    preq = 1'b1;
    pstate = 1'b0;
    repeat (3) tick();
    chk("in_quiesce", 32'({quiesce_req, power_en}), 'b11);
    rst = 1'b1;
    preq = 1'b0;
    tick();
    chk("rst_quiesce", 32'(outs), 0);
    rst = 1'b0;
    handshake(1'b1, lat, ev);
    chk("pwrup_after_rst2", lat, P + 1);
    handshake(1'b0, lat, ev);
    chk("off_after_rst", 32'(lat), QT + 1);
    chk("final_clean", 32'({proto_err, power_en, cur_pstate}), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
